// File: rtl/rv4028_bus_bridge.sv
// rv4028_bus_bridge: FemtoRV32 word memory port to narrow external bus adapter.
// A CPU word access is split into 32/BUS_W bus beats. Each beat lasts at least
// WAIT_STATES+1 cycles and is stretched while wait_n is low. Writes are fully
// buffered so the CPU is free to change address/data after its request cycle.
module rv4028_bus_bridge #(
    parameter int BUS_W       = 16,
    parameter int WAIT_STATES = 0,
    parameter int IO_BIT      = 31
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        mem_addr,
    input  logic [31:0]        mem_wdata,
    input  logic [3:0]         mem_wmask,
    input  logic               mem_rstrb,
    output logic [31:0]        mem_rdata,
    output logic               mem_rbusy,
    output logic               mem_wbusy,
    output logic [31:0]        addr,
    output logic               rd_n,
    output logic               wr_n,
    output logic [BUS_W/8-1:0] wrm_n,
    output logic               iorq_n,
    output logic               mreq_n,
    input  logic               wait_n,
    inout  wire  [BUS_W-1:0]   data
);

    localparam int BEATS = 32 / BUS_W;
    localparam int LANES = BUS_W / 8;
    // With a single beat the counter is a constant-zero bit that synthesis drops.
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);
    localparam logic [LANES-1:0] LANES_OFF = '1;

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    state_t           state;
    logic [CNT_W-1:0] beat;
    logic [3:0]       wcnt;
    logic [29:0]      word_q;
    logic [3:0]       wmask_q;
    logic [31:0]      wdata_q;

    logic             wr_req;
    logic             rd_req;
    logic             beat_done;
    logic             last_rd;
    logic             more_wr;
    logic [CNT_W-1:0] first_wr;
    logic [CNT_W-1:0] next_wr;

    // Word-aligned bus: the CPU byte offset carries no information here.
    wire unused_addr_bits = ^mem_addr[1:0];

    // True when beat b has at least one enabled byte lane.
    function automatic logic lane_hit(input logic [3:0] m, input int b);
        return |m[b*LANES +: LANES];
    endfunction

    // True when some beat at or above 'from' has an enabled lane.
    function automatic logic any_beat_from(input logic [3:0] m, input int from);
        logic hit;
        hit = 1'b0;
        for (int b = 0; b < BEATS; b++)
            if (b >= from && lane_hit(m, b)) hit = 1'b1;
        return hit;
    endfunction

    // Lowest beat at or above 'from' with an enabled lane (0 if none).
    function automatic logic [CNT_W-1:0] first_beat_from(input logic [3:0] m, input int from);
        logic [CNT_W-1:0] idx;
        idx = '0;
        for (int b = BEATS - 1; b >= 0; b--)
            if (b >= from && lane_hit(m, b)) idx = CNT_W'(b);
        return idx;
    endfunction

    // Bus byte address of a beat: word address plus beat offset in bytes.
    function automatic logic [31:0] beat_addr(input logic [29:0] word, input logic [CNT_W-1:0] b);
        return {word, 2'b00} | (32'(b) * 32'(LANES));
    endfunction

    assign wr_req    = |mem_wmask;
    assign rd_req    = mem_rstrb & ~wr_req;
    assign beat_done = (wcnt == 4'd0) && wait_n;
    assign last_rd   = (int'(beat) == BEATS - 1);
    assign first_wr  = first_beat_from(mem_wmask, 0);
    assign next_wr   = first_beat_from(wmask_q, int'(beat) + 1);
    assign more_wr   = any_beat_from(wmask_q, int'(beat) + 1);

    assign mem_rbusy = ((state == IDLE) && rd_req) || (state == READ);

    // wr_n is only low in WRITE, and async reset raises it, releasing the bus at once.
    assign data = wr_n ? {BUS_W{1'bz}} : wdata_q[int'(beat)*BUS_W +: BUS_W];

    // Capture the request payload so the CPU can move on after its request cycle.
    always_ff @(posedge clk) begin
        if (state == IDLE && (wr_req || rd_req))
            word_q <= mem_addr[31:2];
        if (state == IDLE && wr_req) begin
            wmask_q <= mem_wmask;
            wdata_q <= mem_wdata;
        end
    end

    // Transfer FSM: sequences beats, drives registered strobes and captures read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat      <= '0;
            wcnt      <= 4'd0;
            mem_rdata <= 32'd0;
            mem_wbusy <= 1'b0;
            addr      <= 32'd0;
            rd_n      <= 1'b1;
            wr_n      <= 1'b1;
            wrm_n     <= LANES_OFF;
            iorq_n    <= 1'b1;
            mreq_n    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_req) begin
                        state     <= WRITE;
                        beat      <= first_wr;
                        wcnt      <= WS_LOAD;
                        mem_wbusy <= 1'b1;
                        wr_n      <= 1'b0;
                        addr      <= beat_addr(mem_addr[31:2], first_wr);
                        wrm_n     <= ~mem_wmask[int'(first_wr)*LANES +: LANES];
                        iorq_n    <= ~mem_addr[IO_BIT];
                        mreq_n    <= mem_addr[IO_BIT];
                    end else if (rd_req) begin
                        state  <= READ;
                        beat   <= '0;
                        wcnt   <= WS_LOAD;
                        rd_n   <= 1'b0;
                        addr   <= beat_addr(mem_addr[31:2], '0);
                        wrm_n  <= LANES_OFF;
                        iorq_n <= ~mem_addr[IO_BIT];
                        mreq_n <= mem_addr[IO_BIT];
                    end
                end
                READ: begin
                    if (beat_done) begin
                        mem_rdata[int'(beat)*BUS_W +: BUS_W] <= data;
                        if (last_rd) begin
                            state  <= IDLE;
                            rd_n   <= 1'b1;
                            iorq_n <= 1'b1;
                            mreq_n <= 1'b1;
                        end else begin
                            beat <= beat + 1'b1;
                            wcnt <= WS_LOAD;
                            addr <= beat_addr(word_q, beat + 1'b1);
                        end
                    end else if (wcnt != 4'd0) begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                WRITE: begin
                    if (beat_done) begin
                        if (more_wr) begin
                            beat  <= next_wr;
                            wcnt  <= WS_LOAD;
                            addr  <= beat_addr(word_q, next_wr);
                            wrm_n <= ~wmask_q[int'(next_wr)*LANES +: LANES];
                        end else begin
                            state     <= IDLE;
                            mem_wbusy <= 1'b0;
                            wr_n      <= 1'b1;
                            wrm_n     <= LANES_OFF;
                            iorq_n    <= 1'b1;
                            mreq_n    <= 1'b1;
                        end
                    end else if (wcnt != 4'd0) begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv4028_bus_bridge.sv
// tb_rv4028_bus_bridge: four bridge configurations sharing one CPU-side driver,
// a bus slave returning lanes of rd_word, and a per-cycle strobe scoreboard.
module tb_rv4028_bus_bridge;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [31:0] c_addr = 32'd0;
    logic [31:0] c_wdata = 32'd0;
    logic [3:0]  c_wmask = 4'd0;
    logic        c_rstrb = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [31:0] rd_word = 32'd0;

    int cycnt = 0;
    int req_cyc = 0;
    int wlo = 1000;
    int whi = -1;
    wire wait_n = !(((cycnt - req_cyc) >= wlo) && ((cycnt - req_cyc) <= whi));

    always @(posedge clk) cycnt <= cycnt + 1;

    // A: BUS_W=16 WS=0
    logic [31:0] rdata_a, addr_a;
    logic rbusy_a, wbusy_a, rd_a, wr_a, io_a, mr_a;
    logic [1:0] wrm_a;
    wire [15:0] data_a;
    assign data_a = !rd_a ? 16'(rd_word >> {addr_a[1], 4'b0000}) : 16'hzzzz;
    rv4028_bus_bridge #(.BUS_W(16), .WAIT_STATES(0), .IO_BIT(31)) u_a (
        .clk(clk), .rst_n(rst_n), .mem_addr(c_addr), .mem_wdata(c_wdata),
        .mem_wmask(sel == 2'd0 ? c_wmask : 4'h0), .mem_rstrb(sel == 2'd0 && c_rstrb),
        .mem_rdata(rdata_a), .mem_rbusy(rbusy_a), .mem_wbusy(wbusy_a), .addr(addr_a),
        .rd_n(rd_a), .wr_n(wr_a), .wrm_n(wrm_a), .iorq_n(io_a), .mreq_n(mr_a),
        .wait_n(wait_n), .data(data_a));

    // B: BUS_W=8 WS=2
    logic [31:0] rdata_b, addr_b;
    logic rbusy_b, wbusy_b, rd_b, wr_b, io_b, mr_b;
    logic [0:0] wrm_b;
    wire [7:0] data_b;
    assign data_b = !rd_b ? 8'(rd_word >> {addr_b[1:0], 3'b000}) : 8'hzz;
    rv4028_bus_bridge #(.BUS_W(8), .WAIT_STATES(2), .IO_BIT(31)) u_b (
        .clk(clk), .rst_n(rst_n), .mem_addr(c_addr), .mem_wdata(c_wdata),
        .mem_wmask(sel == 2'd1 ? c_wmask : 4'h0), .mem_rstrb(sel == 2'd1 && c_rstrb),
        .mem_rdata(rdata_b), .mem_rbusy(rbusy_b), .mem_wbusy(wbusy_b), .addr(addr_b),
        .rd_n(rd_b), .wr_n(wr_b), .wrm_n(wrm_b), .iorq_n(io_b), .mreq_n(mr_b),
        .wait_n(wait_n), .data(data_b));

    // C: BUS_W=16 WS=1
    logic [31:0] rdata_c, addr_c;
    logic rbusy_c, wbusy_c, rd_c, wr_c, io_c, mr_c;
    logic [1:0] wrm_c;
    wire [15:0] data_c;
    assign data_c = !rd_c ? 16'(rd_word >> {addr_c[1], 4'b0000}) : 16'hzzzz;
    rv4028_bus_bridge #(.BUS_W(16), .WAIT_STATES(1), .IO_BIT(31)) u_c (
        .clk(clk), .rst_n(rst_n), .mem_addr(c_addr), .mem_wdata(c_wdata),
        .mem_wmask(sel == 2'd2 ? c_wmask : 4'h0), .mem_rstrb(sel == 2'd2 && c_rstrb),
        .mem_rdata(rdata_c), .mem_rbusy(rbusy_c), .mem_wbusy(wbusy_c), .addr(addr_c),
        .rd_n(rd_c), .wr_n(wr_c), .wrm_n(wrm_c), .iorq_n(io_c), .mreq_n(mr_c),
        .wait_n(wait_n), .data(data_c));

    // D: BUS_W=32 WS=0
    logic [31:0] rdata_d, addr_d;
    logic rbusy_d, wbusy_d, rd_d, wr_d, io_d, mr_d;
    logic [3:0] wrm_d;
    wire [31:0] data_d;
    assign data_d = !rd_d ? rd_word : 32'hzzzz_zzzz;
    rv4028_bus_bridge #(.BUS_W(32), .WAIT_STATES(0), .IO_BIT(31)) u_d (
        .clk(clk), .rst_n(rst_n), .mem_addr(c_addr), .mem_wdata(c_wdata),
        .mem_wmask(sel == 2'd3 ? c_wmask : 4'h0), .mem_rstrb(sel == 2'd3 && c_rstrb),
        .mem_rdata(rdata_d), .mem_rbusy(rbusy_d), .mem_wbusy(wbusy_d), .addr(addr_d),
        .rd_n(rd_d), .wr_n(wr_d), .wrm_n(wrm_d), .iorq_n(io_d), .mreq_n(mr_d),
        .wait_n(wait_n), .data(data_d));

    typedef struct packed {
        logic rd_n, wr_n, iorq_n, mreq_n, rbusy, wbusy;
        logic [3:0] wrm_n;
        logic [31:0] addr, data, rdata;
    } view_t;

    typedef struct packed {
        logic rd;
        logic io;
        logic [3:0] wrm_n;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    view_t v;
    beat_t exp_q[$];
    beat_t mon_e;

    always_comb begin
        v = '0;
        case (sel)
            2'd0: v = {rd_a, wr_a, io_a, mr_a, rbusy_a, wbusy_a, {2'b00, wrm_a}, addr_a, {16'h0, data_a}, rdata_a};
            2'd1: v = {rd_b, wr_b, io_b, mr_b, rbusy_b, wbusy_b, {3'b000, wrm_b}, addr_b, {24'h0, data_b}, rdata_b};
            2'd2: v = {rd_c, wr_c, io_c, mr_c, rbusy_c, wbusy_c, {2'b00, wrm_c}, addr_c, {16'h0, data_c}, rdata_c};
            default: v = {rd_d, wr_d, io_d, mr_d, rbusy_d, wbusy_d, wrm_d, addr_d, data_d, rdata_d};
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Every cycle a strobe is low must match the next expected beat-cycle.
    always @(negedge clk) begin
        if (rst_n && (!v.rd_n || !v.wr_n)) begin
            check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("strobes", {30'b0, v.rd_n, v.wr_n}, mon_e.rd ? 32'd1 : 32'd2);
                check("bus_addr", v.addr, mon_e.addr);
                check("wrm_n", {28'b0, v.wrm_n}, {28'b0, mon_e.wrm_n});
                check("space", {30'b0, v.iorq_n, v.mreq_n}, mon_e.io ? 32'd1 : 32'd2);
                if (!mon_e.rd) check("wr_data", v.data, mon_e.data);
            end
        end
    end

    task automatic push_read(input int bw, input int ws, input int extra0,
                             input logic [31:0] a, output int cyc);
        int lanes = bw / 8;
        cyc = 0;
        for (int b = 0; b < 32 / bw; b++)
            for (int c = 0; c < ws + 1 + ((b == 0) ? extra0 : 0); c++) begin
                exp_q.push_back('{rd: 1'b1, io: a[31], wrm_n: 4'((1 << lanes) - 1),
                                  addr: {a[31:2], 2'b00} + 32'(b * lanes), data: 32'h0});
                cyc++;
            end
    endtask

    task automatic push_write(input int bw, input int ws, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] m, output int cyc);
        int lanes = bw / 8;
        logic [3:0] full;
        logic [3:0] lm;
        logic [63:0] dmask;
        full = 4'((1 << lanes) - 1);
        dmask = (64'd1 << bw) - 64'd1;
        cyc = 0;
        for (int b = 0; b < 32 / bw; b++) begin
            lm = 4'(m >> (b * lanes)) & full;
            if (lm != 4'd0)
                for (int c = 0; c < ws + 1; c++) begin
                    exp_q.push_back('{rd: 1'b0, io: a[31], wrm_n: ~lm & full,
                                      addr: {a[31:2], 2'b00} + 32'(b * lanes),
                                      data: 32'((64'(d) >> (b * bw)) & dmask)});
                    cyc++;
                end
        end
    endtask

    // Drive one request cycle on instance s; returns one cycle later with requests dropped.
    task automatic issue(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m, input logic r);
        @(posedge clk); #1;
        sel = s; c_addr = a; c_wdata = d; c_wmask = m; c_rstrb = r; req_cyc = cycnt;
        #1;
        if (m != 4'd0) check("wbusy_req_cycle", {31'b0, v.wbusy}, 32'd0);
        else check("rbusy_req_cycle", {31'b0, v.rbusy}, 32'd1);
        @(posedge clk); #1;
        c_wmask = 4'd0; c_rstrb = 1'b0; c_addr = a ^ 32'hDEAD_BEE0; c_wdata = ~d;
    endtask

    // Count cycles from request until busy falls; n=1 on entry.
    task automatic wait_done(input string tag, input int exp_n);
        int n = 1;
        while ((v.rbusy || v.wbusy) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 32'(n), 32'(exp_n));
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [3:0] full;

        // Reset state of every configuration
        @(posedge clk); #1;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            full = (s == 1) ? 4'h1 : (s == 3) ? 4'hF : 4'h3;
            check("rst_strobes", {28'b0, v.rd_n, v.wr_n, v.iorq_n, v.mreq_n}, 32'hF);
            check("rst_wrm_n", {28'b0, v.wrm_n}, {28'b0, full});
            check("rst_addr", v.addr, 32'h0);
            check("rst_rdata", v.rdata, 32'h0);
            check("rst_busy", {30'b0, v.rbusy, v.wbusy}, 32'h0);
        end
        sel = 2'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 16-bit read, no waits
        rd_word = 32'h1234_5678;
        push_read(16, 0, 0, 32'h0000_1004, cyc);
        issue(2'd0, 32'h0000_1004, 32'h0, 4'h0, 1'b1);
        wait_done("rd16_latency", cyc + 1);
        check("rd16_rdata", v.rdata, 32'h1234_5678);

        // 8-bit write, two middle lanes, 2 wait states, IO space
        push_write(8, 2, 32'h8000_0010, 32'hAABB_CCDD, 4'b0110, cyc);
        issue(2'd1, 32'h8000_0010, 32'hAABB_CCDD, 4'b0110, 1'b0);
        wait_done("wr8_latency", 7);

        // 16-bit single-beat writes: upper half then lowest byte
        push_write(16, 0, 32'h0000_2000, 32'h1122_3344, 4'b1100, cyc);
        issue(2'd0, 32'h0000_2000, 32'h1122_3344, 4'b1100, 1'b0);
        wait_done("wr16_hi_latency", cyc + 1);
        push_write(16, 0, 32'h0000_3000, 32'h5566_7788, 4'b0001, cyc);
        issue(2'd0, 32'h0000_3000, 32'h5566_7788, 4'b0001, 1'b0);
        wait_done("wr16_lo_latency", 2);

        // 16-bit read, 1 wait state, wait_n low 3 extra cycles in beat 0
        rd_word = 32'h9ABC_DEF0;
        wlo = 2; whi = 4;
        push_read(16, 1, 3, 32'h0000_4000, cyc);
        issue(2'd2, 32'h0000_4000, 32'h0, 4'h0, 1'b1);
        wait_done("rd16_wait_latency", 8);
        check("rd16_wait_rdata", v.rdata, 32'h9ABC_DEF0);
        wlo = 1000; whi = -1;

        // Read and write requested together, then a read while the write is busy
        push_write(16, 0, 32'h0000_5000, 32'hA5A5_1234, 4'b0011, cyc);
        issue(2'd0, 32'h0000_5000, 32'hA5A5_1234, 4'b0011, 1'b1);
        c_rstrb = 1'b1;
        #1;
        check("rstrb_in_write_rbusy", {31'b0, v.rbusy}, 32'd0);
        check("rstrb_in_write_wbusy", {31'b0, v.wbusy}, 32'd1);
        @(posedge clk); #1;
        c_rstrb = 1'b0;
        check("collide_wbusy_done", {31'b0, v.wbusy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("collide_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset during read beat 1
        rd_word = 32'h0F0E_0D0C;
        push_read(16, 0, 0, 32'h0000_6000, cyc);
        issue(2'd0, 32'h0000_6000, 32'h0, 4'h0, 1'b1);
        @(posedge clk); #1;
        check("pre_rst_rd_n", {31'b0, v.rd_n}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("arst_strobes", {30'b0, v.rd_n, v.wr_n}, 32'h3);
        check("arst_rbusy", {31'b0, v.rbusy}, 32'd0);
        check("arst_rdata", v.rdata, 32'h0);
        check("arst_addr", v.addr, 32'h0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd_word = 32'h1357_2468;
        push_read(16, 0, 0, 32'h0000_6004, cyc);
        issue(2'd0, 32'h0000_6004, 32'h0, 4'h0, 1'b1);
        wait_done("post_rst_latency", 3);
        check("post_rst_rdata", v.rdata, 32'h1357_2468);

        // 32-bit bus: single beat per access
        push_write(32, 0, 32'h0000_2002, 32'hDEAD_BEEF, 4'b1010, cyc);
        issue(2'd3, 32'h0000_2002, 32'hDEAD_BEEF, 4'b1010, 1'b0);
        wait_done("wr32_latency", 2);
        rd_word = 32'hCAFE_F00D;
        push_read(32, 0, 0, 32'h8000_0040, cyc);
        issue(2'd3, 32'h8000_0040, 32'h0, 4'h0, 1'b1);
        wait_done("rd32_latency", 2);
        check("rd32_rdata", v.rdata, 32'hCAFE_F00D);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv4028_bus_bridge.md
Name: rv4028_bus_bridge

Overview:
- Parametrised successor to the RV4028 FemtoRV external-bus adapter.
- Converts the CPU's 32-bit word memory interface (one-cycle read strobe or write mask) into a sequence of narrow external bus beats.
- Bus width is configurable (8/16/32); each beat has programmable fixed wait states plus wait_n stretching.
- Unlike the previous adapter, writes are fully buffered, with a real mem_wbusy, so the CPU does not hold write data.
- Sits between FemtoRV32 and the external memory/IO bus.

Parameters:
- BUS_W, 16, external data width in bits; legal values 8, 16, 32.
- WAIT_STATES, 0, minimum extra cycles per beat before wait_n is sampled; range 0-15.
- IO_BIT, 31, address bit selecting IO space (iorq_n) vs memory space (mreq_n).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_addr  in  32  CPU byte address; bits [1:0] ignored
- mem_wdata  in  32  CPU write data
- mem_wmask  in  4  CPU byte write enables; nonzero for one cycle = write request
- mem_rstrb  in  1  one-cycle read request
- mem_rdata  out  32  read data, registered
- mem_rbusy  out  1  read in progress
- mem_wbusy  out  1  write in progress
- addr  out  32  bus byte address; low log2(BUS_W/8) bits always 0
- rd_n  out  1  bus read strobe
- wr_n  out  1  bus write strobe
- wrm_n  out  BUS_W/8  bus byte write mask, active low
- iorq_n  out  1  low when a strobe is active and addr[IO_BIT]=1
- mreq_n  out  1  low when a strobe is active and addr[IO_BIT]=0
- wait_n  in  1  low = stretch current beat
- data  inout  BUS_W  bus data; driven only in WRITE state, else high-Z

Behaviour:
- N = 32/BUS_W beats per word. Beat b covers CPU byte lanes [b*BUS_W/8 +: BUS_W/8].
- FSM states: IDLE, READ, WRITE.
- Registers: latched word address, wdata, wmask; beat counter (clog2(N) bits, absent when N=1); wait counter.
- Reset (async): state=IDLE; counters=0; mem_rdata=0; addr=0; rd_n=wr_n=1; wrm_n=all 1; iorq_n=mreq_n=1; data high-Z; mem_rbusy=mem_wbusy=0.
- Reset mid-operation aborts the transfer at once; strobes deassert asynchronously and no partial data is committed.
- IDLE, mem_wmask!=0: latch addr/wdata/wmask, go WRITE, beat counter = lowest beat with nonzero lane mask.
- IDLE, mem_rstrb=1 and mem_wmask=0: latch addr, go READ, beat counter=0.
- mem_rstrb and mem_wmask together: write serviced, read dropped (protocol violation).
- Requests arriving outside IDLE are ignored.
- Beat timing: on beat entry the wait counter loads WAIT_STATES and decrements each cycle. The beat completes on the first cycle with wait counter=0 and wait_n=1. Each beat lasts WAIT_STATES+1 cycles minimum.
- Beats are back-to-back; strobes stay low continuously across beats of one transfer.
- addr = {latched[31:2], beat index scaled to bytes} with low bus-alignment bits 0.
- READ: rd_n=0, wr_n=1, wrm_n all 1. Every beat is fetched; mem_rlo-style half reads do not exist.
  - On beat completion, data is captured into its lane slice of mem_rdata.
  - After the last beat, state returns to IDLE.
- mem_rbusy = mem_rstrb(accepted in IDLE) | (state==READ). mem_rdata is valid the first cycle mem_rbusy is low and holds until the next read's captures.
- WRITE: wr_n=0, rd_n=1, data = wdata slice for the beat, wrm_n = ~wmask slice.
  - Beats whose lane mask is all zero are skipped with zero cycles; the counter advances to the next nonzero beat.
  - After the last nonzero beat, state returns to IDLE.
- mem_wbusy = (state==WRITE), registered; it rises the cycle after the request.
- The CPU may change mem_wdata and mem_addr after its request cycle.
- Latency, no waits: a read takes N+1 cycles from rstrb to rbusy low. A write occupies one bus cycle per nonzero beat.
- iorq_n/mreq_n are decoded from the latched addr[IO_BIT] and are both 1 in IDLE.

Test Plan:
- BUS_W=16, WS=0, read 0x0000_1004, bus returns 0x5678 then 0x1234 -> addr 0x1004,0x1006 on consecutive cycles; rd_n low 2 cycles; mem_rdata=0x1234_5678 when rbusy drops at cycle 3.
- BUS_W=8, WS=2, write mask 4'b0110 data 0xAABBCCDD at 0x8000_0010 -> two beats at 0x8000_0011 (0xCC) and 0x8000_0012 (0xBB), each 3 cycles; iorq_n low, mreq_n high; wbusy high exactly 6 cycles.
- BUS_W=16, write mask 4'b1100 -> single beat at addr+2, wrm_n=2'b00, data=wdata[31:16]; mask 4'b0001 -> single beat at addr, wrm_n=2'b10.
- BUS_W=16, WS=1, wait_n held low 3 extra cycles on beat 0 -> beat 0 lasts 5 cycles, beat 1 lasts 2 cycles; rdata correct.
- rstrb and wmask in the same cycle, then rstrb while wbusy is high -> only the write appears on the bus; no rd_n pulse.
- rst_n asserted mid read beat 1 -> rd_n=1, data high-Z and rbusy=0 immediately; mem_rdata=0; the next read after reset is correct.
- BUS_W=32 -> one beat per access; addr[1:0]=0; write wrm_n = ~wmask.
